// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle MIPS-subset control unit. A 12-state Moore FSM
//               steps each instruction through fetch, decode and execute
//               phases and drives the datapath mux selects and write enables.
//               A small ALU decoder turns the internal aluop (plus funct for
//               R-type) into the 3-bit alucontrol.
// Ports       : clk         - single clock, rising-edge
//               reset       - synchronous, active-high
//               op          - opcode from the instruction register
//               funct       - R-type function field
//               zero        - ALU zero flag, gates branch PC update
//               iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//               alusrca, pcen             - 1-bit datapath controls
//               alusrcb[1:0], pcsrc[1:0]  - datapath mux selects
//               alucontrol[2:0]           - ALU operation select
//               state[3:0]                - current FSM state (debug only)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    // FSM state encodings
    localparam logic [3:0] c_FETCH   = 4'd0;
    localparam logic [3:0] c_DECODE  = 4'd1;
    localparam logic [3:0] c_MEMADR  = 4'd2;
    localparam logic [3:0] c_MEMRD   = 4'd3;
    localparam logic [3:0] c_MEMWB   = 4'd4;
    localparam logic [3:0] c_MEMWR   = 4'd5;
    localparam logic [3:0] c_RTYPEEX = 4'd6;
    localparam logic [3:0] c_RTYPEWB = 4'd7;
    localparam logic [3:0] c_BEQEX   = 4'd8;
    localparam logic [3:0] c_ADDIEX  = 4'd9;
    localparam logic [3:0] c_ADDIWB  = 4'd10;
    localparam logic [3:0] c_JEX     = 4'd11;

    // Opcodes
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_dec_state;

    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; op is only consulted in DECODE and MEMADR
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH:  w_next_state = c_DECODE;
            c_DECODE: begin
                case (op)
                    c_OP_LW,
                    c_OP_SW:    w_next_state = c_MEMADR;
                    c_OP_RTYPE: w_next_state = c_RTYPEEX;
                    c_OP_BEQ:   w_next_state = c_BEQEX;
                    c_OP_ADDI:  w_next_state = c_ADDIEX;
                    c_OP_J:     w_next_state = c_JEX;
                    // Undefined opcodes retire as a NOP
                    default:    w_next_state = c_FETCH;
                endcase
            end
            c_MEMADR:  w_next_state = (op == c_OP_SW) ? c_MEMWR : c_MEMRD;
            c_MEMRD:   w_next_state = c_MEMWB;
            c_RTYPEEX: w_next_state = c_RTYPEWB;
            c_ADDIEX:  w_next_state = c_ADDIWB;
            default:   w_next_state = c_FETCH;
        endcase
    end

    // While reset is held the outputs present FETCH values, so the
    // decoder runs off FETCH rather than the (possibly mid-instruction)
    // register contents.
    assign w_dec_state = reset ? c_FETCH : r_state;

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        w_aluop    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (w_dec_state)
            c_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            c_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                alusrcb = 2'b11;
            end
            c_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            c_MEMRD: begin
                iord = 1'b1;
            end
            c_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            c_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            c_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            c_RTYPEWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
            end
            c_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            c_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            c_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            c_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                w_irwrite = 1'b0;
            end
        endcase
    end

    // Write enables are suppressed for as long as reset is asserted
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b01:   alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller. Each scenario task
//               pushes one entry per clock cycle (stimulus plus expected
//               output vector) into a scoreboard queue, then pops the
//               entries one cycle at a time, drives the inputs on the
//               falling edge and compares the DUT outputs shortly after.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic [18:0] w_obs;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [18:0] exp;
        logic [18:0] mask;
        string       tag;
    } entry_t;

    entry_t q[$];

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .pcen       (pcen),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    // {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    //  pcen, alusrcb, pcsrc, alucontrol}
    assign w_obs = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                    alusrca, pcen, alusrcb, pcsrc, alucontrol};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] alu_ref(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector, written directly from the state table
    function automatic logic [18:0] ref_vec(input logic [3:0] st, input logic z,
                                            input logic [5:0] fn, input logic rst);
        if (rst) return {st, 8'b0000_0000, 2'b01, 2'b00, 3'b010};
        case (st)
            4'd0:  return {st, 8'b0010_0001, 2'b01, 2'b00, 3'b010};
            4'd1:  return {st, 8'b0000_0000, 2'b11, 2'b00, 3'b010};
            4'd2:  return {st, 8'b0000_0010, 2'b10, 2'b00, 3'b010};
            4'd3:  return {st, 8'b1000_0000, 2'b00, 2'b00, 3'b010};
            4'd4:  return {st, 8'b0000_1100, 2'b00, 2'b00, 3'b010};
            4'd5:  return {st, 8'b1100_0000, 2'b00, 2'b00, 3'b010};
            4'd6:  return {st, 8'b0000_0010, 2'b00, 2'b00, alu_ref(fn)};
            4'd7:  return {st, 8'b0001_0100, 2'b00, 2'b00, 3'b010};
            4'd8:  return {st, 7'b0000_001, z, 2'b00, 2'b01, 3'b110};
            4'd9:  return {st, 8'b0000_0010, 2'b10, 2'b00, 3'b010};
            4'd10: return {st, 8'b0000_0100, 2'b00, 2'b00, 3'b010};
            4'd11: return {st, 8'b0000_0001, 2'b00, 2'b10, 3'b010};
            default: return 19'h0;
        endcase
    endfunction

    task automatic push(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic [3:0] st, input logic chk_st,
                        input string tag);
        entry_t e;
        e.rst  = r;
        e.op   = o;
        e.fn   = f;
        e.z    = z;
        e.exp  = ref_vec(st, z, f, r);
        e.mask = chk_st ? 19'h7FFFF : 19'h0FFFF;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic push_seq(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] s3,
                            input logic [3:0] s4, input int n, input string tag);
        logic [3:0] sts [5];
        sts = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++) push(1'b0, o, f, z, sts[i], 1'b1, tag);
    endtask

    task automatic test_reset();
        entry_t e;
        push(1'b1, 6'd0, 6'd0, 1'b0, 4'd0, 1'b0, "reset0");
        push(1'b1, 6'd0, 6'd0, 1'b0, 4'd0, 1'b1, "reset1");
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst; op = e.op; funct = e.fn; zero = e.z;
            #1;
            cyc++;
            tests++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.tag, cyc, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_lw_sw_j();
        entry_t e;
        push_seq(6'b100011, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 5, "lw");
        push_seq(6'b101011, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4, "sw");
        push_seq(6'b000010, 6'd0, 1'b0, 4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 3, "j");
        push_seq(6'b001000, 6'd0, 1'b0, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4, "addi");
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst; op = e.op; funct = e.fn; zero = e.z;
            #1;
            cyc++;
            tests++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.tag, cyc, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_rtype();
        entry_t e;
        logic [5:0] fns [6];
        fns = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
        for (int i = 0; i < 6; i++)
            push_seq(6'b000000, fns[i], 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4, "rtype");
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst; op = e.op; funct = e.fn; zero = e.z;
            #1;
            cyc++;
            tests++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.tag, cyc, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_beq_undef();
        entry_t e;
        push_seq(6'b000100, 6'd0, 1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 3, "beq_taken");
        push_seq(6'b000100, 6'd0, 1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 3, "beq_not_taken");
        push_seq(6'b111111, 6'd0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2, "undef");
        push_seq(6'b000101, 6'd0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2, "undef_bne");
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst; op = e.op; funct = e.fn; zero = e.z;
            #1;
            cyc++;
            tests++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.tag, cyc, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_reset_mid_instr();
        entry_t e;
        push_seq(6'b100011, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 3, "lw_pre_reset");
        push(1'b1, 6'b100011, 6'd0, 1'b1, 4'd3, 1'b1, "reset_in_memrd");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 4'd0, 1'b1, "fetch_after_reset");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 4'd1, 1'b1, "decode_after_reset");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 4'd2, 1'b1, "memadr_after_reset");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 4'd3, 1'b1, "memrd_after_reset");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 4'd4, 1'b1, "memwb_after_reset");
        push(1'b0, 6'b000000, 6'd0, 1'b0, 4'd0, 1'b1, "final_fetch");
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst; op = e.op; funct = e.fn; zero = e.z;
            #1;
            cyc++;
            tests++;
            if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                fails++;
                $display("FAIL %s cyc %0d: got %h expected %h", e.tag, cyc, w_obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        test_reset();
        test_lw_sw_j();
        test_rtype();
        test_beq_undef();
        test_reset_mid_instr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op  input  6  instruction opcode, from the instruction register.
REQ-005 SHALL have port funct  input  6  R-type function field.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have outputs iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen; each an output of width 1 carrying the datapath control of the same name.
REQ-008 SHALL have ports alusrcb  output  2, pcsrc  output  2 and alucontrol  output  3 for datapath mux and ALU selects.
REQ-009 SHALL have port state  output  4  current FSM state, for debug and verification only.

Function
REQ-010 SHALL implement a 12-state Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10 and JEX=11.
REQ-011 SHALL decode these opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
REQ-012 SHALL use these transitions: FETCH->DECODE; DECODE->MEMADR on LW/SW, ->RTYPEEX, ->BEQEX, ->ADDIEX, ->JEX; MEMADR->MEMRD on LW, ->MEMWR on SW; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX ->FETCH.
REQ-013 SHALL go DECODE->FETCH on any undefined opcode, with no register or memory write; the instruction is treated as a NOP.
REQ-014 SHALL drive every control output to 0 in a state unless REQ-015..REQ-026 set it.
REQ-015 SHALL assert in FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
REQ-016 SHALL assert in DECODE: alusrcb=11, aluop=00 (branch target precompute).
REQ-017 SHALL assert in MEMADR: alusrca=1, alusrcb=10, aluop=00.
REQ-018 SHALL assert in MEMRD: iord=1.
REQ-019 SHALL assert in MEMWB: regwrite=1, memtoreg=1, regdst=0.
REQ-020 SHALL assert in MEMWR: iord=1, memwrite=1.
REQ-021 SHALL assert in RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
REQ-022 SHALL assert in RTYPEWB: regwrite=1, regdst=1, memtoreg=0.
REQ-023 SHALL assert in BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-024 SHALL assert in ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-025 SHALL assert in ADDIWB: regwrite=1, regdst=0, memtoreg=0.
REQ-026 SHALL assert in JEX: pcsrc=10, pcwrite=1.
REQ-027 SHALL drive pcen = pcwrite | (branch & zero), combinationally, in the same cycle as zero.
REQ-028 SHALL keep pcwrite, branch and aluop internal and SHALL NOT expose them as ports.
REQ-029 SHALL decode alucontrol combinationally from aluop as follows: aluop 00 gives 010 (add); 01 gives 110 (sub); 11 gives 010.
REQ-030 SHALL decode alucontrol from funct when aluop=10: 100000 gives 010; 100010 gives 110; 100100 gives 000; 100101 gives 001; 101010 gives 111; any other funct gives 010.
REQ-031 SHALL produce these instruction latencies in cycles, FETCH to FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, undefined 2.
REQ-032 SHALL derive all outputs from state (and zero/funct only as stated above), with no output depending on op outside DECODE/MEMADR next-state logic.

Reset
REQ-033 SHALL load state=FETCH on any rising clk edge with reset=1, including mid-instruction.
REQ-034 SHALL force pcen, irwrite, regwrite and memwrite to 0 while reset=1, all other outputs taking their FETCH values.
REQ-035 SHALL perform the first FETCH, with irwrite=1 and pcen=1, in the first cycle after reset deasserts.

Verification
REQ-036 SHALL pass this check: reset 2 cycles, then op=100011 -> state 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; iord=1 in state 3.
REQ-037 SHALL pass this check: op=000000, funct=101010 -> states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-038 SHALL pass this check: op=000100 with zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110; repeated with zero=0 -> pcen=0; both return to FETCH next.
REQ-039 SHALL pass this check: op=101011 -> states 0,1,2,5,0, memwrite=1 only in state 5; op=000010 -> states 0,1,11,0 with pcen=1 and pcsrc=10 in state 11.
REQ-040 SHALL pass this check: op=111111 -> states 0,1,0 with no write enable asserted; reset asserted in MEMRD -> state 0 next edge with all write enables 0 during reset.
